psram_access_sequencer: RTL and testbench

- Timing sequencer directly upstream of the memory flag encoder.
- Accepts single-word read/write requests from the audio record/playback logic over a valid/ready handshake.
- Drives registered RE/WE strobes and holds address/data stable for the full asynchronous PSRAM access window. The flag encoder turns RE/WE into the active-low chip controls.
- Captures read data and returns it with a one-cycle response pulse.

---
 rtl/psram_access_sequencer.sv | 102 ++++++++++
 tb/tb_psram_access_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/psram_access_sequencer.sv
// psram_access_sequencer: times single-word PSRAM read/write accesses with registered RE/WE strobes
module psram_access_sequencer #(
   parameter int ADDR_W      = 23,
   parameter int DATA_W      = 16,
   parameter int ACCESS_CYC  = 7,
   parameter int RECOVER_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              RE,
   output logic              WE,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dout,
   output logic              mem_dout_en,
   input  logic [DATA_W-1:0] mem_din,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;
   localparam int MX = ACCESS_CYC > RECOVER_CYC ? ACCESS_CYC : RECOVER_CYC;
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              wr, wr_n, en_n, rv_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] dout_n, rdata_n;
   // next-state and next-output computation; every output below is registered
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_n    = wr;
      addr_n  = mem_addr;
      dout_n  = mem_dout;
      en_n    = mem_dout_en;
      rdata_n = rsp_rdata;
      rv_n    = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            state_n = SETUP;
            wr_n    = req_write;
            addr_n  = req_addr;
            dout_n  = req_write ? req_wdata : mem_dout;
            en_n    = req_write;
         end
         SETUP: begin
            state_n = ACCESS;
            cnt_n   = CW'(ACCESS_CYC - 1);
         end
         ACCESS: if (cnt == '0) begin
            state_n = RECOVER;
            cnt_n   = CW'(RECOVER_CYC - 1);
            rv_n    = !wr;
            rdata_n = wr ? rsp_rdata : mem_din;
         end else begin
            cnt_n = cnt - 1'b1;
         end
         RECOVER: if (cnt == '0) begin
            state_n = IDLE;
            en_n    = 1'b0;
         end else begin
            cnt_n = cnt - 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
   // state and output registers; reset drops any in-flight access immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         wr          <= 1'b0;
         mem_addr    <= '0;
         mem_dout    <= '0;
         mem_dout_en <= 1'b0;
         rsp_rdata   <= '0;
         rsp_valid   <= 1'b0;
         RE          <= 1'b0;
         WE          <= 1'b0;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         wr          <= wr_n;
         mem_addr    <= addr_n;
         mem_dout    <= dout_n;
         mem_dout_en <= en_n;
         rsp_rdata   <= rdata_n;
         rsp_valid   <= rv_n;
         RE          <= state_n == ACCESS && !wr_n;
         WE          <= state_n == ACCESS && wr_n;
         req_ready   <= state_n == IDLE;
         busy        <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_psram_access_sequencer.sv
// tb_psram_access_sequencer: table-driven and directed checks of the PSRAM access sequencer
module tb_psram_access_sequencer;
   logic        clk, rst_n;
   logic        v, w, rdy, rv, re, we, en, bsy;
   logic [22:0] a, ma;
   logic [15:0] d, din, md, rd;
   logic        v2, w2, rdy2, rv2, re2, we2, en2, bsy2;
   logic [22:0] a2, ma2;
   logic [15:0] d2, din2, md2, rd2;
   int          n_chk, n_fail;

   psram_access_sequencer #(.ADDR_W(23), .DATA_W(16), .ACCESS_CYC(3), .RECOVER_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(v), .req_ready(rdy), .req_write(w), .req_addr(a),
      .req_wdata(d), .rsp_valid(rv), .rsp_rdata(rd), .RE(re), .WE(we), .mem_addr(ma),
      .mem_dout(md), .mem_dout_en(en), .mem_din(din), .busy(bsy));

   psram_access_sequencer #(.ADDR_W(23), .DATA_W(16), .ACCESS_CYC(1), .RECOVER_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2), .req_write(w2), .req_addr(a2),
      .req_wdata(d2), .rsp_valid(rv2), .rsp_rdata(rd2), .RE(re2), .WE(we2), .mem_addr(ma2),
      .mem_dout(md2), .mem_dout_en(en2), .mem_din(din2), .busy(bsy2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v, w;
      logic [22:0] a;
      logic [15:0] d, din;
      logic        rdy, re, we, en, rv, bsy;
      logic [22:0] ea;
      logic [15:0] ed, er;
   } vec_t;
   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc_cyc[4];
      int k;
      logic acc, prev_acc;
      logic [22:0] prev_a;
      n_chk = 0; n_fail = 0;
      v = 0; w = 0; a = '0; d = '0; din = '0;
      v2 = 0; w2 = 0; a2 = '0; d2 = '0; din2 = '0;
      // row: inputs for one cycle, then outputs expected after that cycle's edge
      tbl[0]  = '{1, 1, 23'h10,     16'hBEEF, 16'hFFFF, 0, 0, 0, 1, 0, 1, 23'h10,     16'hBEEF, 16'h0};
      tbl[1]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 1, 1, 0, 1, 23'h10,     16'hBEEF, 16'h0};
      tbl[2]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 1, 1, 0, 1, 23'h10,     16'hBEEF, 16'h0};
      tbl[3]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 1, 1, 0, 1, 23'h10,     16'hBEEF, 16'h0};
      tbl[4]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 0, 1, 0, 1, 23'h10,     16'hBEEF, 16'h0};
      tbl[5]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 1, 0, 0, 0, 0, 0, 23'h10,     16'hBEEF, 16'h0};
      tbl[6]  = '{1, 0, 23'h7FFFFF, 16'h0,    16'hFFFF, 0, 0, 0, 0, 0, 1, 23'h7FFFFF, 16'hBEEF, 16'h0};
      tbl[7]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 1, 0, 0, 0, 1, 23'h7FFFFF, 16'hBEEF, 16'h0};
      tbl[8]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 1, 0, 0, 0, 1, 23'h7FFFFF, 16'hBEEF, 16'h0};
      tbl[9]  = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 1, 0, 0, 0, 1, 23'h7FFFFF, 16'hBEEF, 16'h0};
      tbl[10] = '{0, 0, 23'h0,      16'h0,    16'h1234, 0, 0, 0, 0, 1, 1, 23'h7FFFFF, 16'hBEEF, 16'h1234};
      tbl[11] = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 1, 0, 0, 0, 0, 0, 23'h7FFFFF, 16'hBEEF, 16'h1234};
      tbl[12] = '{1, 1, 23'h55,     16'h0F0F, 16'hFFFF, 0, 0, 0, 1, 0, 1, 23'h55,     16'h0F0F, 16'h1234};
      tbl[13] = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 1, 1, 0, 1, 23'h55,     16'h0F0F, 16'h1234};
      tbl[14] = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 1, 1, 0, 1, 23'h55,     16'h0F0F, 16'h1234};
      tbl[15] = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 1, 1, 0, 1, 23'h55,     16'h0F0F, 16'h1234};
      tbl[16] = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 0, 0, 0, 1, 0, 1, 23'h55,     16'h0F0F, 16'h1234};
      tbl[17] = '{0, 0, 23'h0,      16'h0,    16'hFFFF, 1, 0, 0, 0, 0, 0, 23'h55,     16'h0F0F, 16'h1234};

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_re", re, 0); chk("rst_we", we, 0); chk("rst_rv", rv, 0); chk("rst_en", en, 0);
      chk("rst_busy", bsy, 0); chk("rst_ready", rdy, 1);
      chk("rst_addr", ma, 0); chk("rst_dout", md, 0); chk("rst_rdata", rd, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 18; i++) begin
         v = tbl[i].v; w = tbl[i].w; a = tbl[i].a; d = tbl[i].d; din = tbl[i].din;
         step();
         chk($sformatf("t%0d_ready", i), rdy, tbl[i].rdy);
         chk($sformatf("t%0d_re", i), re, tbl[i].re);
         chk($sformatf("t%0d_we", i), we, tbl[i].we);
         chk($sformatf("t%0d_en", i), en, tbl[i].en);
         chk($sformatf("t%0d_rv", i), rv, tbl[i].rv);
         chk($sformatf("t%0d_busy", i), bsy, tbl[i].bsy);
         chk($sformatf("t%0d_addr", i), ma, tbl[i].ea);
         chk($sformatf("t%0d_dout", i), md, tbl[i].ed);
         chk($sformatf("t%0d_rdata", i), rd, tbl[i].er);
      end

      k = 0;
      prev_a = ma;
      for (int c = 0; c < 24; c++) begin
         v = c <= 18; w = k[0]; a = 23'h100 + 23'(k); d = 16'h2000 + 16'(k);
         acc = v && rdy;
         if (acc && k < 4) acc_cyc[k] = c;
         if (acc) k++;
         step();
         chk("b2b_excl", re & we, 0);
         chk($sformatf("b2b_addr_chg%0d", c), ma != prev_a, acc);
         if (acc) chk("b2b_addr", ma, 23'h100 + 23'(k - 1));
         prev_a = ma;
      end
      chk("b2b_count", k, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("b2b_acc%0d", i), acc_cyc[i], 6 * i);
      v = 0;

      v = 1; w = 1; a = 23'h200; d = 16'h1111;
      step();
      for (int c = 1; c <= 5; c++) begin
         w = 1'($urandom); a = 23'($urandom); d = 16'($urandom);
         step();
         chk("imm_addr", ma, 23'h200);
         chk("imm_dout", md, 16'h1111);
         chk("imm_we", we, c + 1 <= 4);
         chk("imm_re", re, 0);
         chk("imm_ready", rdy, c + 1 == 6);
      end
      v = 0;
      step();
      chk("imm_noacc_addr", ma, 23'h200);
      chk("imm_noacc_busy", bsy, 0);

      v = 1; w = 1; a = 23'h300; d = 16'h3333;
      step();
      v = 0;
      step(); step();
      chk("rst_mid_we_before", we, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_we", we, 0); chk("rst_mid_en", en, 0); chk("rst_mid_rv", rv, 0);
      chk("rst_mid_ready", rdy, 1); chk("rst_mid_busy", bsy, 0);
      step(); step();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("rst_after_rv", rv, 0);
         chk("rst_after_ready", rdy, 1);
         chk("rst_after_busy", bsy, 0);
      end

      v2 = 1; w2 = 0; a2 = 23'h42; din2 = 16'hFFFF;
      step();
      v2 = 0;
      chk("p_c1_re", re2, 0); chk("p_c1_addr", ma2, 23'h42); chk("p_c1_ready", rdy2, 0);
      step();
      chk("p_c2_re", re2, 1); chk("p_c2_we", we2, 0); chk("p_c2_en", en2, 0);
      din2 = 16'hA5A5;
      step();
      din2 = 16'h0;
      chk("p_c3_re", re2, 0); chk("p_c3_rv", rv2, 1); chk("p_c3_rdata", rd2, 16'hA5A5);
      step();
      chk("p_c4_rv", rv2, 0); chk("p_c4_ready", rdy2, 0); chk("p_c4_busy", bsy2, 1);
      step();
      chk("p_c5_ready", rdy2, 1); chk("p_c5_busy", bsy2, 0); chk("p_c5_rdata", rd2, 16'hA5A5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
